// File: rtl/hipercubo_control.sv
// Purpose: sequences the 2x2 Hipercubo multiplier: captures A/B, drives ENa/ENb/ENc/SEL, flags the result.
// Latency: VALID rises 4 cycles after the edge that accepts START; back-to-back gives one result every 5 cycles.
// Backpressure: the result holds in DONE until ACK; START is ignored while busy or while a result is unacknowledged.
module hipercubo_control (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ACK,
    input  logic [3:0] XA00,
    input  logic [3:0] XA01,
    input  logic [3:0] XA10,
    input  logic [3:0] XA11,
    input  logic [3:0] XB00,
    input  logic [3:0] XB01,
    input  logic [3:0] XB10,
    input  logic [3:0] XB11,
    output logic [3:0] A00,
    output logic [3:0] A01,
    output logic [3:0] A10,
    output logic [3:0] A11,
    output logic [3:0] B00,
    output logic [3:0] B01,
    output logic [3:0] B10,
    output logic [3:0] B11,
    output logic [7:0] ENa,
    output logic [7:0] ENb,
    output logic [7:0] ENc,
    output logic [7:0] SEL,
    output logic       BUSY,
    output logic       VALID,
    output logic [7:0] COUNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_XFER1 = 3'd2,
        S_XFER2 = 3'd3,
        S_CAPT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;

    // State register; reset wins over every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, START acceptance and Moore output decode (outputs depend on state only).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ENa       = 8'h00;
        ENb       = 8'h00;
        ENc       = 8'h00;
        SEL       = 8'h00;
        BUSY      = 1'b0;
        VALID     = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // External coefficients into nodes 000..011.
                ENa       = 8'h0F;
                ENb       = 8'h0F;
                BUSY      = 1'b1;
                state_nxt = S_XFER1;
            end
            S_XFER1: begin
                // A01/A11 up to nodes 101/111, B10/B11 up to nodes 110/111.
                ENa       = 8'hA0;
                ENb       = 8'hC0;
                BUSY      = 1'b1;
                state_nxt = S_XFER2;
            end
            S_XFER2: begin
                // Second hop through the alternate mux inputs completes every operand pair.
                ENa       = 8'h5A;
                ENb       = 8'h3C;
                SEL       = 8'hFF;
                BUSY      = 1'b1;
                state_nxt = S_CAPT;
            end
            S_CAPT: begin
                ENc       = 8'hFF;
                BUSY      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                VALID = 1'b1;
                if (ACK) begin
                    if (START) begin
                        accept    = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Coefficient holding registers; only an accepted START changes them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            A00 <= 4'd0;
            A01 <= 4'd0;
            A10 <= 4'd0;
            A11 <= 4'd0;
            B00 <= 4'd0;
            B01 <= 4'd0;
            B10 <= 4'd0;
            B11 <= 4'd0;
        end else if (accept) begin
            A00 <= XA00;
            A01 <= XA01;
            A10 <= XA10;
            A11 <= XA11;
            B00 <= XB00;
            B01 <= XB01;
            B10 <= XB10;
            B11 <= XB11;
        end
    end

    // Completed-operation counter, bumped on CAPT->DONE, wraps naturally at 8 bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            COUNT <= 8'd0;
        end else if (state == S_CAPT) begin
            COUNT <= COUNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_hipercubo_control.sv
module tb_hipercubo_control;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       ACK;
    logic [3:0] XA00, XA01, XA10, XA11;
    logic [3:0] XB00, XB01, XB10, XB11;
    logic [3:0] A00, A01, A10, A11;
    logic [3:0] B00, B01, B10, B11;
    logic [7:0] ENa, ENb, ENc, SEL;
    logic       BUSY;
    logic       VALID;
    logic [7:0] COUNT;

    int errors = 0;
    int checks = 0;

    hipercubo_control dut (
        .CLK(CLK), .RST(RST), .START(START), .ACK(ACK),
        .XA00(XA00), .XA01(XA01), .XA10(XA10), .XA11(XA11),
        .XB00(XB00), .XB01(XB01), .XB10(XB10), .XB11(XB11),
        .A00(A00), .A01(A01), .A10(A10), .A11(A11),
        .B00(B00), .B01(B01), .B10(B10), .B11(B11),
        .ENa(ENa), .ENb(ENb), .ENc(ENc), .SEL(SEL),
        .BUSY(BUSY), .VALID(VALID), .COUNT(COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural hypercube: node k register sources, gated by the controller's enables/selects.
    logic [3:0] ra [8];
    logic [3:0] rb [8];
    logic [7:0] rc [8];
    logic [7:0] mtx00, mtx01, mtx10, mtx11;

    always @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 8; k++) begin
                ra[k] <= 4'd0;
                rb[k] <= 4'd0;
                rc[k] <= 8'd0;
            end
        end else begin
            if (ENa[0]) ra[0] <= A00;
            if (ENa[1]) ra[1] <= SEL[1] ? ra[0] : A01;
            if (ENa[2]) ra[2] <= A10;
            if (ENa[3]) ra[3] <= SEL[3] ? ra[2] : A11;
            if (ENa[4]) ra[4] <= ra[5];
            if (ENa[5]) ra[5] <= ra[1];
            if (ENa[6]) ra[6] <= ra[7];
            if (ENa[7]) ra[7] <= ra[3];
            if (ENb[0]) rb[0] <= B00;
            if (ENb[1]) rb[1] <= B01;
            if (ENb[2]) rb[2] <= SEL[2] ? rb[0] : B10;
            if (ENb[3]) rb[3] <= SEL[3] ? rb[1] : B11;
            if (ENb[4]) rb[4] <= rb[6];
            if (ENb[5]) rb[5] <= rb[7];
            if (ENb[6]) rb[6] <= rb[2];
            if (ENb[7]) rb[7] <= rb[3];
            for (int k = 0; k < 8; k++) begin
                if (ENc[k]) rc[k] <= ra[k] * rb[k];
            end
        end
    end

    assign mtx00 = rc[0] + rc[4];
    assign mtx01 = rc[1] + rc[5];
    assign mtx10 = rc[2] + rc[6];
    assign mtx11 = rc[3] + rc[7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ab(input logic [3:0] a00, a01, a10, a11, b00, b01, b10, b11);
        XA00 = a00; XA01 = a01; XA10 = a10; XA11 = a11;
        XB00 = b00; XB01 = b01; XB10 = b10; XB11 = b11;
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; ACK = 1'b0;
        set_ab(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        step();
        step();
        checks++;
        if ({ENa, ENb, ENc, SEL} !== 32'h0) begin
            errors++; $display("FAIL reset_enables got=%h exp=0", {ENa, ENb, ENc, SEL});
        end
        checks++;
        if ({BUSY, VALID, COUNT} !== 10'h0) begin
            errors++; $display("FAIL reset_status got=%h exp=0", {BUSY, VALID, COUNT});
        end
        checks++;
        if ({A00, A01, A10, A11, B00, B01, B10, B11} !== 32'h0) begin
            errors++; $display("FAIL reset_hold got=%h exp=0", {A00, A01, A10, A11, B00, B01, B10, B11});
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] ea [5];
        logic [7:0] eb [5];
        logic [7:0] ec [5];
        logic [7:0] es [5];
        logic [4:0] eby;
        logic [4:0] evl;
        ea = '{8'h0F, 8'hA0, 8'h5A, 8'h00, 8'h00};
        eb = '{8'h0F, 8'hC0, 8'h3C, 8'h00, 8'h00};
        ec = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        es = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        eby = 5'b01111;
        evl = 5'b10000;
        set_ab(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8);
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ENa !== ea[i] || ENb !== eb[i] || ENc !== ec[i] || SEL !== es[i]) begin
                errors++;
                $display("FAIL basic_state%0d ENa/ENb/ENc/SEL got=%h/%h/%h/%h exp=%h/%h/%h/%h",
                         i, ENa, ENb, ENc, SEL, ea[i], eb[i], ec[i], es[i]);
            end
            checks++;
            if (BUSY !== eby[i] || VALID !== evl[i]) begin
                errors++;
                $display("FAIL basic_state%0d BUSY/VALID got=%b/%b exp=%b/%b", i, BUSY, VALID, eby[i], evl[i]);
            end
            if (i < 4) step();
        end
        checks++;
        if ({mtx00, mtx01, mtx10, mtx11} !== {8'd19, 8'd22, 8'd43, 8'd50}) begin
            errors++; $display("FAIL basic_mtx got=%0d,%0d,%0d,%0d exp=19,22,43,50", mtx00, mtx01, mtx10, mtx11);
        end
        checks++;
        if (COUNT !== 8'd1) begin
            errors++; $display("FAIL basic_count got=%0d exp=1", COUNT);
        end
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        checks++;
        if (VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL basic_ack_idle VALID/BUSY got=%b/%b exp=0/0", VALID, BUSY);
        end
    endtask

    task automatic test_wrap15();
        set_ab(4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15);
        START = 1'b1;
        step();
        START = 1'b0;
        set_ab(4'd0, 4'd3, 4'd0, 4'd7, 4'd0, 4'd1, 4'd0, 4'd2);
        step();
        XA00 = 4'd9; XA11 = 4'd5;
        checks++;
        if (A00 !== 4'd15 || A11 !== 4'd15 || B01 !== 4'd15) begin
            errors++; $display("FAIL wrap_hold_busy A00/A11/B01 got=%0d/%0d/%0d exp=15/15/15", A00, A11, B01);
        end
        step();
        step();
        step();
        checks++;
        if ({mtx00, mtx01, mtx10, mtx11} !== {4{8'd194}} || VALID !== 1'b1) begin
            errors++; $display("FAIL wrap_mtx got=%0d,%0d,%0d,%0d v=%b exp=194x4 v=1", mtx00, mtx01, mtx10, mtx11, VALID);
        end
        ACK = 1'b1;
        step();
        ACK = 1'b0;
    endtask

    task automatic test_ack_hold();
        RST = 1'b1;
        step();
        RST = 1'b0;
        set_ab(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8);
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            START = i[0];
            set_ab(4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd0, 4'd0, 4'd1);
            step();
            checks++;
            if (VALID !== 1'b1 || BUSY !== 1'b0 || mtx00 !== 8'd19 || mtx11 !== 8'd50 || COUNT !== 8'd1) begin
                errors++;
                $display("FAIL ack_hold_cycle%0d V/B/m00/m11/cnt got=%b/%b/%0d/%0d/%0d exp=1/0/19/50/1",
                         i, VALID, BUSY, mtx00, mtx11, COUNT);
            end
        end
        checks++;
        if (A00 !== 4'd1 || B11 !== 4'd8) begin
            errors++; $display("FAIL ack_hold_coeffs A00/B11 got=%0d/%0d exp=1/8", A00, B11);
        end
        ACK = 1'b1;
        START = 1'b1;
        step();
        ACK = 1'b0;
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || VALID !== 1'b0 || ENa !== 8'h0F) begin
            errors++; $display("FAIL b2b_load B/V/ENa got=%b/%b/%h exp=1/0/0f", BUSY, VALID, ENa);
        end
        step();
        step();
        step();
        checks++;
        if (VALID !== 1'b0) begin
            errors++; $display("FAIL b2b_early_valid got=%b exp=0", VALID);
        end
        step();
        checks++;
        if ({mtx00, mtx01, mtx10, mtx11} !== {8'd2, 8'd3, 8'd4, 8'd5} || VALID !== 1'b1 || COUNT !== 8'd2) begin
            errors++;
            $display("FAIL b2b_identity got=%0d,%0d,%0d,%0d v=%b cnt=%0d exp=2,3,4,5 v=1 cnt=2",
                     mtx00, mtx01, mtx10, mtx11, VALID, COUNT);
        end
    endtask

    task automatic test_reset_mid();
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        set_ab(4'd9, 4'd9, 4'd9, 4'd9, 4'd3, 4'd3, 4'd3, 4'd3);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        checks++;
        if (ENa !== 8'h5A || SEL !== 8'hFF) begin
            errors++; $display("FAIL mid_in_xfer2 ENa/SEL got=%h/%h exp=5a/ff", ENa, SEL);
        end
        RST = 1'b1;
        START = 1'b1;
        ACK = 1'b1;
        step();
        RST = 1'b0;
        START = 1'b0;
        ACK = 1'b0;
        checks++;
        if ({ENa, ENb, ENc, SEL, BUSY, VALID, COUNT} !== 42'h0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h exp=0", {ENa, ENb, ENc, SEL, BUSY, VALID, COUNT});
        end
        checks++;
        if ({A00, A11, B00, B11} !== 16'h0 || {mtx00, mtx01, mtx10, mtx11} !== 32'h0) begin
            errors++; $display("FAIL mid_reset_data hold=%h mtx=%h exp=0", {A00, A11, B00, B11}, {mtx00, mtx01, mtx10, mtx11});
        end
        set_ab(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8);
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (4) step();
        checks++;
        if ({mtx00, mtx01, mtx10, mtx11} !== {8'd19, 8'd22, 8'd43, 8'd50} || COUNT !== 8'd1 || VALID !== 1'b1) begin
            errors++;
            $display("FAIL mid_rerun got=%0d,%0d,%0d,%0d cnt=%0d v=%b exp=19,22,43,50 cnt=1 v=1",
                     mtx00, mtx01, mtx10, mtx11, COUNT, VALID);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_cnt;
        RST = 1'b1;
        step();
        RST = 1'b0;
        set_ab(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8);
        START = 1'b1;
        step();
        START = 1'b0;
        for (int n = 1; n <= 256; n++) begin
            exp_cnt = 8'(n);
            step();
            step();
            step();
            step();
            checks++;
            if (VALID !== 1'b1 || COUNT !== exp_cnt || mtx01 !== 8'd22) begin
                errors++;
                $display("FAIL b2b_op%0d v/cnt/m01 got=%b/%0d/%0d exp=1/%0d/22", n, VALID, COUNT, mtx01, exp_cnt);
            end
            ACK = 1'b1;
            START = (n < 256);
            step();
            ACK = 1'b0;
            START = 1'b0;
        end
        checks++;
        if (COUNT !== 8'd0 || BUSY !== 1'b0 || VALID !== 1'b0) begin
            errors++; $display("FAIL b2b_wrap_end cnt/B/V got=%0d/%b/%b exp=0/0/0", COUNT, BUSY, VALID);
        end
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        ACK = 1'b0;
        set_ab(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_basic();
        test_wrap15();
        test_ack_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hipercubo_control.md
# hipercubo_control

Sequencing controller that sits directly upstream of the `Hipercubo` 2x2 hypercube matrix multiplier. It accepts a start request and captures the two 2x2 matrices of 4-bit coefficients. It then drives the hypercube's register enables (`ENa`, `ENb`, `ENc`) and mux selects (`SEL`) through the load, transfer and capture schedule, and signals when `MTX00..MTX11` hold C = A·B. A valid/ack handshake and a completed-operation counter are included.

## Interface
- Parameters: none. All widths are fixed by `Hipercubo`.
- `CLK`  in  1  master clock, rising edge.
- `RST`  in  1  master reset; synchronous, active-high.
- `START`  in  1  request; sampled only in IDLE, or in DONE together with `ACK`.
- `ACK`  in  1  consumer acknowledges the result.
- `XA00,XA01,XA10,XA11`  in  4 each  matrix A coefficients, captured on an accepted `START`.
- `XB00,XB01,XB10,XB11`  in  4 each  matrix B coefficients, captured on an accepted `START`.
- `A00,A01,A10,A11,B00,B01,B10,B11`  out  4 each  held coefficients driven to `Hipercubo`.
- `ENa,ENb,ENc`  out  8 each  hypercube register enables; bit k = node k.
- `SEL`  out  8  hypercube mux selects. `SEL[k]`=1 selects the mux's second data input.
- `BUSY`  out  1  sequence in progress.
- `VALID`  out  1  `MTX` outputs hold the product.
- `COUNT`  out  8  completed multiplications.

## Operation
- Holding registers: 8×4 bit. They load from `XA*`/`XB*` only on an accepted `START`, and hold otherwise.
- The FSM has states IDLE, LOAD, XFER1, XFER2, CAPT, DONE.
- All control outputs are Moore-decoded from the state register. There is no combinational path from any input to any output.
- Per-state outputs (all outputs not listed are 0):
  - IDLE: all enables and selects 0; `BUSY`=0, `VALID`=0.
    - `START`=1 → LOAD; capture coefficients.
  - LOAD: `ENa`=`ENb`=0x0F, `SEL`=0x00.
    - Loads external A/B into nodes 000–011.
    - → XFER1.
  - XFER1: `ENa`=0xA0, `ENb`=0xC0, `SEL`=0x00.
    - Ra101←A01, Ra111←A11, Rb110←B10, Rb111←B11.
    - → XFER2.
  - XFER2: `ENa`=0x5A, `ENb`=0x3C, `SEL`=0xFF.
    - Ra001←A00, Ra011←A10, Ra100←A01, Ra110←A11.
    - Rb010←B00, Rb011←B01, Rb100←B10, Rb101←B11.
    - → CAPT.
  - CAPT: `ENc`=0xFF.
    - Each node's product is latched into its Rc register.
    - → DONE.
  - DONE: all enables 0, `VALID`=1, `BUSY`=0.
    - Results hold until acknowledged.
    - `ACK`=1 and `START`=0 → IDLE.
    - `ACK`=1 and `START`=1 → LOAD; capture new coefficients (back-to-back).
    - `ACK`=0 → stay; `START` is ignored.
- `BUSY`=1 in LOAD, XFER1, XFER2 and CAPT.
- `START` is ignored in the busy states. Held coefficients do not change while busy.
- `COUNT` increments by 1 on the CAPT→DONE transition and wraps from 255 to 0.
- Arithmetic is performed in `Hipercubo`. Each `MTX` entry is the sum of two 4×4-bit products, taken mod 256, so the maximum 450 reads as 194.

## Timing
- Edge e0 samples `START`=1 in IDLE. e1 ends LOAD, e2 ends XFER1, e3 ends XFER2, and e4 ends CAPT.
- `VALID` is high from e4, a latency of 4 cycles.
- `VALID` stays high and `MTX` stays stable until the edge that samples `ACK`=1.
- Back-to-back throughput: one result every 5 cycles when `ACK` and `START` are asserted together in DONE.
- Reset at any time, including mid-sequence, returns the block to IDLE at the next edge:
  - all enables, `SEL` and holding registers go to 0;
  - `BUSY`=0, `VALID`=0, `COUNT`=0.
- Reset has priority over `START` and `ACK`.
- `Hipercubo` shares `RST`, so `MTX` reads 0 after reset.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]] with a 1-cycle `START` → `VALID` at e4; `MTX00`=19, `MTX01`=22, `MTX10`=43, `MTX11`=50; `COUNT`=1.
- Per-state output check on the same run:
  - `ENa` steps through 0x0F, 0xA0, 0x5A, 0x00, 0x00.
  - `ENb` steps through 0x0F, 0xC0, 0x3C, 0x00, 0x00.
  - `ENc`=0xFF only in CAPT.
  - `SEL`=0xFF only in XFER2.
- All coefficients 15 → every `MTX` entry reads 194 (mod-256 wrap). Toggling `XA*` while `BUSY`=1 leaves the result unchanged.
- Hold `ACK`=0 for 10 cycles in DONE while pulsing `START` → `VALID` stays 1, results stable, no new sequence. Then `ACK`=1 together with `START`=1 and identity B → A returned at e4 after the ack edge; `COUNT`=2.
- Assert `RST` during XFER2 → next cycle IDLE; all outputs 0; `COUNT`=0. A subsequent `START` completes correctly.
- 256 back-to-back operations → `COUNT` wraps 255→0.
